// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: single-request initiator on the big-endian, word-wide
// data memory port. Sub-word loads are lane-extracted and extended;
// sub-word stores are done as a read-modify-write of the containing word.
module lsu_mem_ctrl #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr,
  output logic        mem_rd,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wr_data_q, mem_wr_data_d;
  logic        mem_wr_q, mem_wr_d;
  logic        mem_rd_q, mem_rd_d;

  // Latched request fields (data only, never reset)
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;

  logic        req_err;
  logic [32:0] last_byte;

  // Pick the addressed lane (big-endian) and sign- or zero-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h   = off[1] ? word[15:0] : word[31:16];
    ext = word;
    if (size == 2'b00) begin
      if (uns) ext = {24'h0, b};
      else     ext = 32'(b);
    end else if (size == 2'b01) begin
      if (uns) ext = {16'h0, h};
      else     ext = 32'(h);
    end
    return ext;
  endfunction

  // Replace only the target lane of the fetched word with the store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic [15:0] wdata);
    logic [31:0] m;
    m = word;
    if (size == 2'b01) begin
      if (off[1]) m[15:0]  = wdata;
      else        m[31:16] = wdata;
    end else begin
      case (off)
        2'd0:    m[31:24] = wdata[7:0];
        2'd1:    m[23:16] = wdata[7:0];
        2'd2:    m[15:8]  = wdata[7:0];
        default: m[7:0]   = wdata[7:0];
      endcase
    end
    return m;
  endfunction

  // Range check in 33 bits so high address bits can never wrap into range.
  assign last_byte = {1'b0, req_addr[31:2], 2'b00} + 33'd3;
  assign req_err   = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (|req_addr[1:0]))
                   | (last_byte >= 33'(MEM_BYTES));

  // Next-state and next-output computation for the request FSM
  always_comb begin
    state_d       = state_q;
    req_ready_d   = 1'b0;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = 32'h0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_d      = 1'b0;
    mem_rd_d      = 1'b0;
    we_d          = we_q;
    size_d        = size_q;
    uns_d         = uns_q;
    off_d         = off_q;
    wdata_d       = wdata_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        mem_addr_d  = 32'h0;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          we_d        = req_we;
          size_d      = req_size;
          uns_d       = req_unsigned;
          off_d       = req_addr[1:0];
          wdata_d     = req_wdata[15:0];
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we && req_size == 2'b10) begin
            state_d       = WR;
            mem_wr_d      = 1'b1;
            mem_addr_d    = {req_addr[31:2], 2'b00};
            mem_wr_data_d = req_wdata;
          end else begin
            state_d    = RD;
            mem_rd_d   = 1'b1;
            mem_addr_d = {req_addr[31:2], 2'b00};
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_d       = WR;
          mem_wr_d      = 1'b1;
          mem_wr_data_d = merge_store(mem_rd_data, size_q, off_q, wdata_q);
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_extract(mem_rd_data, size_q, off_q, uns_q);
          mem_addr_d   = 32'h0;
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        mem_addr_d   = 32'h0;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        mem_addr_d  = 32'h0;
      end
    endcase
  end

  // State and registered outputs; request fields are held through reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= 32'h0;
      mem_addr_q    <= 32'h0;
      mem_wr_data_q <= 32'h0;
      mem_wr_q      <= 1'b0;
      mem_rd_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_rdata_q  <= resp_rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_q      <= mem_wr_d;
      mem_rd_q      <= mem_rd_d;
      we_q          <= we_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      off_q         <= off_d;
      wdata_q       <= wdata_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr      = mem_wr_q;
  assign mem_rd      = mem_rd_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: byte-array memory model, directed request
// sequence, and a response scoreboard checked on the falling edge.
module tb_lsu_mem_ctrl;
  localparam int MEM_BYTES = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr;
  logic        mem_rd;
  logic [31:0] mem_rd_data;
  logic        mem_init;

  lsu_mem_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  // Memory model: big-endian bytes, combinational read, write on the edge
  logic [7:0] mem [0:MEM_BYTES-1];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h11; mem[1] <= 8'h22; mem[2] <= 8'h33; mem[3] <= 8'h44;
      mem[4] <= 8'h85; mem[5] <= 8'h66; mem[6] <= 8'h77; mem[7] <= 8'h88;
    end else if (mem_wr && mem_addr < 32'(MEM_BYTES)) begin
      mem[mem_addr[7:0]]         <= mem_wr_data[31:24];
      mem[mem_addr[7:0] + 8'd1]  <= mem_wr_data[23:16];
      mem[mem_addr[7:0] + 8'd2]  <= mem_wr_data[15:8];
      mem[mem_addr[7:0] + 8'd3]  <= mem_wr_data[7:0];
    end
  end

  always_comb begin
    mem_rd_data = 32'h0;
    if (mem_addr < 32'(MEM_BYTES))
      mem_rd_data = {mem[mem_addr[7:0]], mem[mem_addr[7:0] + 8'd1],
                     mem[mem_addr[7:0] + 8'd2], mem[mem_addr[7:0] + 8'd3]};
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          rd;
    int          wr;
    logic [31:0] wdata;
    logic [31:0] maddr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wdata = 32'h0;
  logic [31:0] last_maddr = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Monitor: per-cycle invariants, strobe bookkeeping, scoreboard pops
  initial forever @(negedge clk) begin
    if (rst) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      check("rd_wr_exclusive", 32'(mem_rd && mem_wr), 32'd0);
      check("ready_outside_idle", 32'(req_ready && (mem_rd || mem_wr || resp_valid)), 32'd0);
      if (mem_rd) begin rd_cnt++; last_maddr = mem_addr; end
      if (mem_wr) begin wr_cnt++; last_maddr = mem_addr; last_wdata = mem_wr_data; end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", 32'(resp_err), 32'(e.err));
          check("resp_cycle", 32'(cyc), 32'(e.cyc));
          check("rd_strobes", 32'(rd_cnt), 32'(e.rd));
          check("wr_strobes", 32'(wr_cnt), 32'(e.wr));
          check("resp_mem_addr", mem_addr, 32'h0);
          if (e.wr > 0) check("wr_data", last_wdata, e.wdata);
          if (e.rd > 0 || e.wr > 0) check("strobe_addr", last_maddr, e.maddr);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Wait for ready, present a request, and record its expected response
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int lat, input int erd, input int ewr,
                       input logic [31:0] ewdata, input logic push,
                       input logic hold, output int acc);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    acc          = cyc;
    @(posedge clk);
    if (push) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = acc + lat;
      e.rd    = erd;
      e.wr    = ewr;
      e.wdata = ewdata;
      e.maddr = {addr[31:2], 2'b00};
      sb.push_back(e);
    end
    if (!hold) #1 req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wr_data"}, mem_wr_data, 32'h0);
    check({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
    check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
  endtask

  initial begin
    int a0, a1, n;
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0; mem_init = 1'b0;

    // Loads with extension
    issue(0, 2'b10, 0, 32'h0, 32'h0, 32'h11223344, 0, 2, 1, 0, 32'h0, 1, 0, a0);
    issue(0, 2'b00, 0, 32'h4, 32'h0, 32'hFFFFFF85, 0, 2, 1, 0, 32'h0, 1, 0, a0);
    issue(0, 2'b00, 1, 32'h4, 32'h0, 32'h00000085, 0, 2, 1, 0, 32'h0, 1, 0, a0);
    issue(0, 2'b01, 0, 32'h4, 32'h0, 32'hFFFF8566, 0, 2, 1, 0, 32'h0, 1, 0, a0);
    issue(0, 2'b01, 1, 32'h6, 32'h0, 32'h00007788, 0, 2, 1, 0, 32'h0, 1, 0, a0);
    issue(0, 2'b10, 1, 32'h4, 32'h0, 32'h85667788, 0, 2, 1, 0, 32'h0, 1, 0, a0);

    // Sub-word store (read-modify-write) then read back
    issue(1, 2'b00, 0, 32'h5, 32'hDEADBEAB, 32'h0, 0, 3, 1, 1, 32'h85AB7788, 1, 0, a0);
    issue(0, 2'b10, 0, 32'h4, 32'h0, 32'h85AB7788, 0, 2, 1, 0, 32'h0, 1, 0, a0);

    // Reset during the RD cycle of a byte store: aborted, no write
    issue(1, 2'b00, 0, 32'h1, 32'h000000FF, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, a0);
    @(negedge clk);
    check("abort_rd_cycle", 32'(mem_rd), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    check("midrst_no_wr", 32'(mem_wr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_wr_after", 32'(mem_wr), 32'd0);
    check("midrst_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'h11223344);
    issue(0, 2'b10, 0, 32'h0, 32'h0, 32'h11223344, 0, 2, 1, 0, 32'h0, 1, 0, a0);

    // Halfword store, word store, and their readbacks
    issue(1, 2'b01, 0, 32'h2, 32'h0000CAFE, 32'h0, 0, 3, 1, 1, 32'h1122CAFE, 1, 0, a0);
    issue(0, 2'b10, 0, 32'h0, 32'h0, 32'h1122CAFE, 0, 2, 1, 0, 32'h0, 1, 0, a0);
    issue(1, 2'b10, 0, 32'h8, 32'hA5A5A5A5, 32'h0, 0, 2, 0, 1, 32'hA5A5A5A5, 1, 0, a0);
    issue(0, 2'b10, 0, 32'h8, 32'h0, 32'hA5A5A5A5, 0, 2, 1, 0, 32'h0, 1, 0, a0);
    issue(0, 2'b10, 0, 32'hFC, 32'h0, 32'h0, 0, 2, 1, 0, 32'h0, 1, 0, a0);

    // Error cases: single-cycle response, no strobes
    issue(1, 2'b01, 0, 32'h3, 32'h1234, 32'h0, 1, 1, 0, 0, 32'h0, 1, 0, a0);
    issue(0, 2'b10, 0, 32'h102, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 1, 0, a0);
    issue(0, 2'b10, 0, 32'h100, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 1, 0, a0);
    issue(0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 1, 0, a0);
    issue(0, 2'b10, 0, 32'h80000000, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 1, 0, a0);
    issue(0, 2'b00, 1, 32'hFF, 32'h0, 32'h0, 0, 2, 1, 0, 32'h0, 1, 0, a0);

    // Back-to-back with req_valid held high throughout
    issue(0, 2'b10, 0, 32'h0, 32'h0, 32'h1122CAFE, 0, 2, 1, 0, 32'h0, 1, 1, a0);
    issue(0, 2'b10, 0, 32'h4, 32'h0, 32'h85AB7788, 0, 2, 1, 0, 32'h0, 1, 0, a1);
    check("b2b_spacing", 32'(a1 - a0), 32'd3);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit acting as the initiator on the data memory interface. It accepts one pipeline load/store request at a time and drives the word-wide, big-endian, byte-addressed data memory port (mem_addr, mem_wr_data, mem_wr, mem_rd, mem_rd_data). It performs byte and halfword extraction with sign or zero extension, and does read-modify-write for sub-word stores. It sits between the MEM pipeline stage and data memory; the pipeline stalls while req_ready is low.

Parameters:
MEM_BYTES, 256, size of data memory in bytes; any access touching a byte at or above MEM_BYTES is an error.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both high
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  valid with resp_valid: misaligned, out-of-range or illegal size
mem_addr  output  32  word-aligned address to data memory
mem_wr_data  output  32  write word to data memory
mem_wr  output  1  memory write strobe
mem_rd  output  1  memory read strobe
mem_rd_data  input  32  combinational read data from memory

Behaviour:
- All outputs are registered; none is a combinational function of the request inputs. Data memory writes are level-sensitive, so mem_addr and mem_wr_data are stable for the entire cycle mem_wr is high.
- Reset values: req_ready=1 (state IDLE), resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wr_data=0, mem_wr=0, mem_rd=0.
- States: IDLE, RD, WR, RESP.
- On accept, the block latches we, size, unsigned, addr, wdata and computes the error condition.
- Error condition: size==11; or half with addr[0]!=0; or word with addr[1:0]!=0; or (addr & ~3) + 3 >= MEM_BYTES.
- Transitions out of IDLE on accept:
  - Error -> RESP with resp_err=1 and no memory strobe.
  - Load -> RD.
  - Word store -> WR.
  - Byte or half store -> RD.
- RD (one cycle): mem_rd=1, mem_wr=0, mem_addr={addr[31:2],2'b00}. Capture mem_rd_data at the end of the cycle.
  - Load: go to RESP.
  - Sub-word store: go to WR.
- WR (one cycle): mem_wr=1, mem_rd=0, same mem_addr.
  - Word store: mem_wr_data=wdata.
  - Sub-word store: mem_wr_data is the captured word with only the target lane replaced.
  - Then go to RESP.
- RESP (one cycle): resp_valid=1, all memory strobes 0, mem_addr=0. Then go to IDLE.
- mem_rd and mem_wr are never high in the same cycle.
- Byte lanes are big-endian:
  - Byte offset k occupies word bits [31-8k : 24-8k].
  - Halfword at offset 0 is [31:16]; at offset 2 it is [15:0].
- Loads: extract the lane, then sign-extend (req_unsigned=0) or zero-extend (req_unsigned=1). Word loads ignore req_unsigned.
- Latency, counted from the accept edge as cycle 0:
  - Load: resp_valid in cycle 2.
  - Word store: resp_valid in cycle 2.
  - Sub-word store: resp_valid in cycle 3.
  - Error: resp_valid in cycle 1.
  - req_ready returns high the cycle after RESP. Maximum throughput is one request per 3 or 4 cycles.
- Inputs are ignored while not in IDLE; req_valid held high is not re-accepted until req_ready is high again.
- Reset mid-operation: rst sampled high at any edge forces IDLE and reset output values at that edge.
  - A write whose WR cycle was already in progress completes.
  - If rst hits during RD of a sub-word store, no write occurs.
  - No response is issued for an aborted request.
- Address bits above MEM_BYTES range are checked, never truncated.

Test Plan:
- Memory bytes 0x00..0x07 = 11 22 33 44 85 66 77 88. LW addr 0x0 -> resp_rdata=0x11223344, resp_err=0, resp_valid in cycle 2, mem_rd high exactly 1 cycle with mem_addr=0.
- Load extension:
  - LB addr 0x4 -> 0xFFFFFF85.
  - LBU addr 0x4 -> 0x00000085.
  - LH addr 0x4 -> 0xFFFF8566.
  - LHU addr 0x6 -> 0x00007788.
- SB addr 0x5, wdata 0xDEADBEAB -> RD cycle then WR cycle with mem_wr_data=0x85AB7788, resp_valid in cycle 3; a following LW addr 0x4 returns 0x85AB7788. Also SH addr 0x2, wdata 0x0000CAFE -> word 0 becomes 0x1122CAFE.
- Errors, each giving resp_err=1 in cycle 1, resp_rdata=0, and no mem_rd/mem_wr assertion:
  - SH addr 0x3.
  - LW addr 0x102.
  - LW addr 0x100 (MEM_BYTES=256).
  - req_size=11.
- Back-to-back: req_valid held high with LW 0x0 then LW 0x4 -> second accepted only in the cycle after resp_valid; each response is correct; req_ready is never high outside IDLE.
- Reset mid-operation: rst during RD of SB addr 0x1, wdata 0xFF -> no mem_wr ever, word 0 still 0x11223344, all outputs at reset values, req_ready=1 the next cycle.
